// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, fill level and sticky overflow/underflow flags.
module sync_fifo_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_inc,
  input  logic [WIDTH-1:0]         i_datain,
  output logic                     o_wr_full,
  output logic                     o_wr_afull,
  input  logic                     i_rd_inc,
  output logic [WIDTH-1:0]         o_dataout,
  output logic                     o_rd_empty,
  output logic                     o_rd_aempty,
  output logic [$clog2(DEPTH):0]   o_level,
  input  logic                     i_clr_err,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned ADDR_SIZE = $clog2(DEPTH);

  localparam logic [ADDR_SIZE:0] LevelFull  = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] LevelAfull = (ADDR_SIZE + 1)'(AFULL_TH);
  localparam logic [ADDR_SIZE:0] LevelAempt = (ADDR_SIZE + 1)'(AEMPTY_TH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_SIZE-1:0] wptr_q, rptr_q;
  logic [ADDR_SIZE:0]   level_q;
  logic                 ovf_q, udf_q;
  logic                 wr_ok, rd_ok;

  // Flags decode the registered level only, so a same-cycle read never frees a slot
  // for a write and a same-cycle write never feeds a read.
  always_comb begin
    o_wr_full   = (level_q == LevelFull);
    o_rd_empty  = (level_q == '0);
    o_wr_afull  = (level_q >= LevelAfull);
    o_rd_aempty = (level_q <= LevelAempt);
    o_level     = level_q;
    o_overflow  = ovf_q;
    o_underflow = udf_q;
    wr_ok       = i_wr_inc & ~o_wr_full;
    rd_ok       = i_rd_inc & ~o_rd_empty;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + ADDR_SIZE'(1);
      if (rd_ok) rptr_q <= rptr_q + ADDR_SIZE'(1);

      unique case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + (ADDR_SIZE + 1)'(1);
        2'b01:   level_q <= level_q - (ADDR_SIZE + 1)'(1);
        default: level_q <= level_q;
      endcase

      // A new error in the same cycle as a clear takes priority.
      if (i_wr_inc & o_wr_full) ovf_q <= 1'b1;
      else if (i_clr_err)       ovf_q <= 1'b0;

      if (i_rd_inc & o_rd_empty) udf_q <= 1'b1;
      else if (i_clr_err)        udf_q <= 1'b0;
    end
  end

  // Storage is not reset; a write in a reset cycle is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_ok) mem[wptr_q] <= i_datain;
  end

  if (FWFT != 0) begin : g_fwft
    assign o_dataout = mem[rptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge i_clk) begin
      if (i_rst)      dout_q <= '0;
      else if (rd_ok) dout_q <= mem[rptr_q];
    end

    assign o_dataout = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read instance and one FWFT instance
// driven by hand-built vectors with hand-computed expectations.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Standard-mode instance
  logic       s_rst = 1'b1, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
  logic [7:0] s_din = '0, s_dout;
  logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
  logic [4:0] s_level;

  // FWFT instance
  logic       f_rst = 1'b1, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
  logic [4:0] f_level;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_std (
    .i_clk(clk), .i_rst(s_rst), .i_wr_inc(s_wr), .i_datain(s_din),
    .o_wr_full(s_full), .o_wr_afull(s_afull), .i_rd_inc(s_rd), .o_dataout(s_dout),
    .o_rd_empty(s_empty), .o_rd_aempty(s_aempty), .o_level(s_level),
    .i_clr_err(s_clr), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_fwft (
    .i_clk(clk), .i_rst(f_rst), .i_wr_inc(f_wr), .i_datain(f_din),
    .o_wr_full(f_full), .o_wr_afull(f_afull), .i_rd_inc(f_rd), .o_dataout(f_dout),
    .o_rd_empty(f_empty), .o_rd_aempty(f_aempty), .o_level(f_level),
    .i_clr_err(f_clr), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_flags(input int lvl);
    check_eq("std_level", 32'(s_level), 32'(lvl));
    check_eq("std_full", 32'(s_full), 32'(lvl == 16));
    check_eq("std_empty", 32'(s_empty), 32'(lvl == 0));
    check_eq("std_afull", 32'(s_afull), 32'(lvl >= 14));
    check_eq("std_aempty", 32'(s_aempty), 32'(lvl <= 2));
  endtask

  initial begin
    // Reset state
    tick();
    s_rst = 1'b0;
    f_rst = 1'b0;
    check_std_flags(0);
    check_eq("rst_ovf", 32'(s_ovf), 32'd0);
    check_eq("rst_udf", 32'(s_udf), 32'd0);
    check_eq("rst_dout", 32'(s_dout), 32'd0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      s_wr = 1'b1; s_din = 8'(i);
      tick();
      check_std_flags(i);
    end

    // Write while full is rejected and sets overflow
    s_din = 8'hAA;
    tick();
    s_wr = 1'b0;
    check_eq("ovf_set", 32'(s_ovf), 32'd1);
    check_std_flags(16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      s_rd = 1'b1;
      tick();
      check_eq("pop_data", 32'(s_dout), 32'(i));
      check_std_flags(16 - i);
    end
    s_rd = 1'b0;
    check_eq("ovf_sticky", 32'(s_ovf), 32'd1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check_eq("ovf_clr", 32'(s_ovf), 32'd0);

    // Hold level 8 with simultaneous write/read; pointers wrap several times
    for (int k = 0; k < 8; k++) begin
      s_wr = 1'b1; s_din = 8'(8'h20 + k);
      tick();
    end
    check_std_flags(8);
    for (int k = 0; k < 40; k++) begin
      s_wr = 1'b1; s_rd = 1'b1; s_din = 8'(8'h28 + k);
      tick();
      check_eq("steady_data", 32'(s_dout), 32'(8'h20 + k));
      check_eq("steady_level", 32'(s_level), 32'd8);
    end
    s_wr = 1'b0;
    for (int k = 40; k < 48; k++) begin
      s_rd = 1'b1;
      tick();
      check_eq("tail_data", 32'(s_dout), 32'(8'h20 + k));
    end
    s_rd = 1'b0;
    check_std_flags(0);

    // Read while empty with a same-cycle write: read rejected, write accepted
    s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h55;
    tick();
    s_wr = 1'b0; s_rd = 1'b0;
    check_eq("udf_set", 32'(s_udf), 32'd1);
    check_std_flags(1);
    check_eq("udf_dout_hold", 32'(s_dout), 32'h4F);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check_eq("udf_clr", 32'(s_udf), 32'd0);
    s_rd = 1'b1;
    tick();
    check_eq("pop_55", 32'(s_dout), 32'h55);
    // Set and clear together: set wins
    s_clr = 1'b1;
    tick();
    s_rd = 1'b0; s_clr = 1'b0;
    check_eq("udf_set_wins", 32'(s_udf), 32'd1);

    // Reset mid-operation at level 5 with wr+rd active
    for (int k = 0; k < 5; k++) begin
      s_wr = 1'b1; s_din = 8'(8'h60 + k);
      tick();
    end
    check_std_flags(5);
    s_rst = 1'b1; s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h77;
    tick();
    s_rst = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
    check_std_flags(0);
    check_eq("mid_rst_ovf", 32'(s_ovf), 32'd0);
    check_eq("mid_rst_udf", 32'(s_udf), 32'd0);
    check_eq("mid_rst_dout", 32'(s_dout), 32'd0);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    check_eq("post_rst_udf", 32'(s_udf), 32'd1);
    check_eq("post_rst_dout", 32'(s_dout), 32'd0);

    // FWFT: a write into an empty FIFO shows up without a read
    f_wr = 1'b1; f_din = 8'h3C;
    tick();
    f_wr = 1'b0;
    check_eq("fwft_head", 32'(f_dout), 32'h3C);
    check_eq("fwft_empty", 32'(f_empty), 32'd0);
    f_wr = 1'b1; f_din = 8'h3D;
    tick();
    f_wr = 1'b0;
    check_eq("fwft_head_hold", 32'(f_dout), 32'h3C);
    check_eq("fwft_level2", 32'(f_level), 32'd2);
    f_rd = 1'b1;
    tick();
    check_eq("fwft_next", 32'(f_dout), 32'h3D);
    check_eq("fwft_level1", 32'(f_level), 32'd1);
    // Write and read together at level 1: the new word becomes the head
    f_wr = 1'b1; f_din = 8'h3E;
    tick();
    f_wr = 1'b0;
    check_eq("fwft_swap_head", 32'(f_dout), 32'h3E);
    check_eq("fwft_swap_level", 32'(f_level), 32'd1);
    tick();
    f_rd = 1'b0;
    check_eq("fwft_drained", 32'(f_empty), 32'd1);
    check_eq("fwft_no_udf", 32'(f_udf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
